// File: rtl/voice_pkg.sv
// -----------------------------------------------------------------------------
// voice_pkg
// Shared definitions for the voice allocator: message type encodings, voice
// count, field widths, the allocator FSM state type and a small decode helper.
// No ports (package).
// -----------------------------------------------------------------------------
package voice_pkg;

  localparam int VOICES = 4;
  localparam int NOTE_W = 7;
  localparam int VEL_W  = 7;
  localparam int AGE_W  = 8;

  // msg_type encodings as delivered by the MIDI parser
  localparam logic [1:0] MSG_NOTE_OFF = 2'd0;
  localparam logic [1:0] MSG_NOTE_ON  = 2'd1;
  localparam logic [1:0] MSG_PROG     = 2'd2;
  localparam logic [1:0] MSG_ALL_OFF  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // A note-on with zero velocity is a note-off in disguise.
  function automatic logic is_note_on(input logic [1:0] msg_type,
                                      input logic [6:0] vel);
    return (msg_type == MSG_NOTE_ON) && (vel != 7'd0);
  endfunction

endpackage

// File: rtl/voice_slot.sv
// -----------------------------------------------------------------------------
// voice_slot
// One voice slot: note number, velocity, saturating age and sustained flag.
// Strobes are mutually exclusive in practice; priority is
// clear > write > release > (hold, age_inc).
// Ports:
//   i_clk, i_rst (async active-high), i_ce   clocking
//   i_write, i_note, i_vel                   load note/vel, age <= 0, flag <= 0
//   i_release                                vel <= 0, flag <= 0, note kept
//   i_hold                                   set sustained flag
//   i_age_inc                                saturating age increment
//   i_clear                                  vel <= 0, age <= 0, flag <= 0
//   o_note, o_vel, o_age, o_sustained        registered slot state
// -----------------------------------------------------------------------------
module voice_slot
  import voice_pkg::*;
#(
  parameter int NOTE_W = voice_pkg::NOTE_W,
  parameter int VEL_W  = voice_pkg::VEL_W,
  parameter int AGE_W  = voice_pkg::AGE_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ce,
  input  logic              i_write,
  input  logic [NOTE_W-1:0] i_note,
  input  logic [VEL_W-1:0]  i_vel,
  input  logic              i_release,
  input  logic              i_hold,
  input  logic              i_age_inc,
  input  logic              i_clear,
  output logic [NOTE_W-1:0] o_note,
  output logic [VEL_W-1:0]  o_vel,
  output logic [AGE_W-1:0]  o_age,
  output logic              o_sustained
);

  logic [NOTE_W-1:0] r_note;
  logic [VEL_W-1:0]  r_vel;
  logic [AGE_W-1:0]  r_age;
  logic              r_sustained;

  // Slot state update; note number survives release so the NCO keeps pitch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_note      <= {NOTE_W{1'b0}};
      r_vel       <= {VEL_W{1'b0}};
      r_age       <= {AGE_W{1'b0}};
      r_sustained <= 1'b0;
    end else if (i_ce) begin
      if (i_clear) begin
        r_vel       <= {VEL_W{1'b0}};
        r_age       <= {AGE_W{1'b0}};
        r_sustained <= 1'b0;
      end else if (i_write) begin
        r_note      <= i_note;
        r_vel       <= i_vel;
        r_age       <= {AGE_W{1'b0}};
        r_sustained <= 1'b0;
      end else if (i_release) begin
        r_vel       <= {VEL_W{1'b0}};
        r_sustained <= 1'b0;
      end else begin
        if (i_hold) begin
          r_sustained <= 1'b1;
        end
        // Saturate so a long-held voice never wraps back to "youngest".
        if (i_age_inc && (r_age != {AGE_W{1'b1}})) begin
          r_age <= r_age + AGE_W'(1);
        end
      end
    end
  end

  assign o_note      = r_note;
  assign o_vel       = r_vel;
  assign o_age       = r_age;
  assign o_sustained = r_sustained;

endmodule

// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
// Turns parsed MIDI channel messages into four voice slots for nco_bank.
// Policy: retrigger a held note in place, else take the first free slot,
// else steal the oldest slot (lowest index on equal age).
//
// Flow: IDLE accepts a message; note messages walk the four slots in SCAN
// (one per ce cycle) to find match/free/oldest; COMMIT applies the result.
// Program change and all-notes-off go straight from IDLE to COMMIT.
//
// Optional feature (macro VOICE_ALLOC_SUSTAIN_EN): adds input i_sustain.
// Note-offs arriving while sustain is held mark the slot sustained instead of
// releasing it; a sustain falling edge costs one COMMIT cycle (msg_ready low)
// that releases every sustained slot, ahead of any waiting message.
//
// Ports:
//   i_clk, i_rst (async active-high), i_ce (clock enable)
//   i_sustain                       sustain pedal (feature builds only)
//   i_msg_valid / o_msg_ready       message handshake, transfer on ce
//   i_msg_type, i_msg_d1, i_msg_d2  message type, note/program, velocity
//   o_note_num_0..3, o_note_vel_0..3  registered slot outputs (vel 0 = free)
//   o_program                       registered current program
// -----------------------------------------------------------------------------
module voice_allocator #(
  parameter int NOTE_W = voice_pkg::NOTE_W,
  parameter int VEL_W  = voice_pkg::VEL_W,
  parameter int AGE_W  = voice_pkg::AGE_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ce,
`ifdef VOICE_ALLOC_SUSTAIN_EN
  input  logic              i_sustain,
`endif
  input  logic              i_msg_valid,
  output logic              o_msg_ready,
  input  logic [1:0]        i_msg_type,
  input  logic [6:0]        i_msg_d1,
  input  logic [6:0]        i_msg_d2,
  output logic [NOTE_W-1:0] o_note_num_0,
  output logic [NOTE_W-1:0] o_note_num_1,
  output logic [NOTE_W-1:0] o_note_num_2,
  output logic [NOTE_W-1:0] o_note_num_3,
  output logic [VEL_W-1:0]  o_note_vel_0,
  output logic [VEL_W-1:0]  o_note_vel_1,
  output logic [VEL_W-1:0]  o_note_vel_2,
  output logic [VEL_W-1:0]  o_note_vel_3,
  output logic [6:0]        o_program
);

  import voice_pkg::*;

  // FSM and latched message
  state_t      r_state;
  logic        r_msg_ready;
  logic [1:0]  r_type;
  logic [6:0]  r_d1;
  logic [6:0]  r_d2;
  logic        r_msg_sus;     // sustain level at the time the message arrived
  logic        r_sus_rel;     // current COMMIT is a sustain release
  logic        r_sus_prev;
  logic        r_pend;        // sustain falling edge waiting for service
  logic [6:0]  r_program;

  // Scan results
  logic [1:0]       r_idx;
  logic             r_match_found;
  logic [1:0]       r_match_idx;
  logic             r_free_found;
  logic [1:0]       r_free_idx;
  logic [1:0]       r_old_idx;
  logic [AGE_W-1:0] r_old_age;

  // Slot views and strobes
  logic [NOTE_W-1:0] w_note [VOICES];
  logic [VEL_W-1:0]  w_vel  [VOICES];
  logic [AGE_W-1:0]  w_age  [VOICES];
  logic [VOICES-1:0] w_flag;
  logic [VOICES-1:0] w_active;
  logic [VOICES-1:0] w_hit;
  logic [VOICES-1:0] w_wr;
  logic [VOICES-1:0] w_rel;
  logic [VOICES-1:0] w_hold;
  logic [VOICES-1:0] w_inc;
  logic [VOICES-1:0] w_clr;
  logic [1:0]        w_target;
  logic              w_commit;
  logic              w_sus;
  logic              w_fall;
  logic [AGE_W-1:0]  w_cur_age;

`ifdef VOICE_ALLOC_SUSTAIN_EN
  assign w_sus = i_sustain;
`else
  assign w_sus = 1'b0;
`endif

  assign w_fall    = r_sus_prev & ~w_sus;
  assign w_commit  = (r_state == ST_COMMIT) & i_ce;
  assign w_cur_age = w_age[r_idx];

  // Per-slot activity and note match against the latched note number.
  always_comb begin
    w_active = {VOICES{1'b0}};
    w_hit    = {VOICES{1'b0}};
    for (int i = 0; i < VOICES; i++) begin
      w_active[i] = (w_vel[i] != {VEL_W{1'b0}});
      w_hit[i]    = w_active[i] && (w_note[i] == NOTE_W'(r_d1));
    end
  end

  // Note-on target: retrigger a match, else first free, else oldest.
  always_comb begin
    if (r_match_found) begin
      w_target = r_match_idx;
    end else if (r_free_found) begin
      w_target = r_free_idx;
    end else begin
      w_target = r_old_idx;
    end
  end

  // COMMIT strobes to the slots.
  always_comb begin
    w_wr   = {VOICES{1'b0}};
    w_rel  = {VOICES{1'b0}};
    w_hold = {VOICES{1'b0}};
    w_inc  = {VOICES{1'b0}};
    w_clr  = {VOICES{1'b0}};
    if (w_commit) begin
      if (r_sus_rel) begin
        w_rel = w_flag;
      end else begin
        case (r_type)
          MSG_NOTE_ON, MSG_NOTE_OFF: begin
            if (is_note_on(r_type, r_d2)) begin
              for (int i = 0; i < VOICES; i++) begin
                if (w_target == 2'(i)) begin
                  w_wr[i] = 1'b1;
                end else begin
                  w_inc[i] = w_active[i];
                end
              end
            end else if (r_msg_sus) begin
              w_hold = w_hit;
            end else begin
              w_rel = w_hit;
            end
          end
          MSG_ALL_OFF: w_clr = {VOICES{1'b1}};
          default:     w_clr = {VOICES{1'b0}};
        endcase
      end
    end else begin
      w_wr = {VOICES{1'b0}};
    end
  end

  // Four slot instances.
  for (genvar g = 0; g < VOICES; g++) begin : g_slot
    voice_slot #(
      .NOTE_W (NOTE_W),
      .VEL_W  (VEL_W),
      .AGE_W  (AGE_W)
    ) u_slot (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_ce        (i_ce),
      .i_write     (w_wr[g]),
      .i_note      (NOTE_W'(r_d1)),
      .i_vel       (VEL_W'(r_d2)),
      .i_release   (w_rel[g]),
      .i_hold      (w_hold[g]),
      .i_age_inc   (w_inc[g]),
      .i_clear     (w_clr[g]),
      .o_note      (w_note[g]),
      .o_vel       (w_vel[g]),
      .o_age       (w_age[g]),
      .o_sustained (w_flag[g])
    );
  end

  // Control FSM; msg_ready is registered and always equals (IDLE && !pending).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_msg_ready   <= 1'b1;
      r_type        <= 2'd0;
      r_d1          <= 7'd0;
      r_d2          <= 7'd0;
      r_msg_sus     <= 1'b0;
      r_sus_rel     <= 1'b0;
      r_sus_prev    <= 1'b0;
      r_pend        <= 1'b0;
      r_program     <= 7'd0;
      r_idx         <= 2'd0;
      r_match_found <= 1'b0;
      r_match_idx   <= 2'd0;
      r_free_found  <= 1'b0;
      r_free_idx    <= 2'd0;
      r_old_idx     <= 2'd0;
      r_old_age     <= {AGE_W{1'b0}};
    end else if (i_ce) begin
      r_sus_prev <= w_sus;
      case (r_state)
        ST_IDLE: begin
          if (r_pend) begin
            // Pedal release wins over any waiting message.
            r_state     <= ST_COMMIT;
            r_sus_rel   <= 1'b1;
            r_pend      <= w_fall;
            r_msg_ready <= 1'b0;
          end else if (i_msg_valid && r_msg_ready) begin
            r_type        <= i_msg_type;
            r_d1          <= i_msg_d1;
            r_d2          <= i_msg_d2;
            r_msg_sus     <= w_sus;
            r_sus_rel     <= 1'b0;
            r_idx         <= 2'd0;
            r_match_found <= 1'b0;
            r_free_found  <= 1'b0;
            r_pend        <= w_fall;
            r_msg_ready   <= 1'b0;
            if ((i_msg_type == MSG_NOTE_ON) || (i_msg_type == MSG_NOTE_OFF)) begin
              r_state <= ST_SCAN;
            end else begin
              r_state <= ST_COMMIT;
            end
          end else begin
            r_pend      <= w_fall;
            r_msg_ready <= ~w_fall;
          end
        end
        ST_SCAN: begin
          if (w_hit[r_idx] && !r_match_found) begin
            r_match_found <= 1'b1;
            r_match_idx   <= r_idx;
          end
          if (!w_active[r_idx] && !r_free_found) begin
            r_free_found <= 1'b1;
            r_free_idx   <= r_idx;
          end
          // Strictly greater keeps the lower index on equal age.
          if ((r_idx == 2'd0) || (w_cur_age > r_old_age)) begin
            r_old_idx <= r_idx;
            r_old_age <= w_cur_age;
          end
          if (r_idx == 2'd3) begin
            r_state <= ST_COMMIT;
          end else begin
            r_idx <= r_idx + 2'd1;
          end
          r_pend      <= r_pend | w_fall;
          r_msg_ready <= 1'b0;
        end
        ST_COMMIT: begin
          if (!r_sus_rel && (r_type == MSG_PROG)) begin
            r_program <= r_d1;
          end
          r_state     <= ST_IDLE;
          r_sus_rel   <= 1'b0;
          r_pend      <= r_pend | w_fall;
          r_msg_ready <= ~(r_pend | w_fall);
        end
        default: begin
          r_state     <= ST_IDLE;
          r_msg_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_msg_ready  = r_msg_ready;
  assign o_program    = r_program;
  assign o_note_num_0 = w_note[0];
  assign o_note_num_1 = w_note[1];
  assign o_note_num_2 = w_note[2];
  assign o_note_num_3 = w_note[3];
  assign o_note_vel_0 = w_vel[0];
  assign o_note_vel_1 = w_vel[1];
  assign o_note_vel_2 = w_vel[2];
  assign o_note_vel_3 = w_vel[3];

endmodule

// File: tb/tb_voice_allocator.sv
// -----------------------------------------------------------------------------
// tb_voice_allocator
// Scoreboard bench: each accepted message updates a behavioural slot model and
// pushes the expected slot/program snapshot plus the ce-cycle count at which
// msg_ready must return. A monitor pops on every msg_ready rise and compares.
// -----------------------------------------------------------------------------
module tb_voice_allocator;

  logic       clk;
  logic       rst;
  logic       ce;
  logic       msg_valid;
  logic       msg_ready;
  logic [1:0] msg_type;
  logic [6:0] d1;
  logic [6:0] d2;
  logic [6:0] nn0, nn1, nn2, nn3;
  logic [6:0] nv0, nv1, nv2, nv3;
  logic [6:0] prog;
`ifdef VOICE_ALLOC_SUSTAIN_EN
  logic       sustain;
`endif

  voice_allocator dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ce         (ce),
`ifdef VOICE_ALLOC_SUSTAIN_EN
    .i_sustain    (sustain),
`endif
    .i_msg_valid  (msg_valid),
    .o_msg_ready  (msg_ready),
    .i_msg_type   (msg_type),
    .i_msg_d1     (d1),
    .i_msg_d2     (d2),
    .o_note_num_0 (nn0),
    .o_note_num_1 (nn1),
    .o_note_num_2 (nn2),
    .o_note_num_3 (nn3),
    .o_note_vel_0 (nv0),
    .o_note_vel_1 (nv1),
    .o_note_vel_2 (nv2),
    .o_note_vel_3 (nv3),
    .o_program    (prog)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0][6:0] note;
    logic [3:0][6:0] vel;
    logic [6:0]      prog;
    logic [31:0]     due;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  int m_note[4];
  int m_vel[4];
  int m_age[4];
  bit m_sus[4];
  int m_prog;

  int checks  = 0;
  int errors  = 0;
  int ce_cnt  = 0;
  int ce_mode = 0;   // 0: always on, 1: random, 2: alternate
  bit ce_tog  = 1'b0;
  bit tb_sus  = 1'b0;

  function automatic int dut_note(int i);
    case (i)
      0: return int'(nn0);
      1: return int'(nn1);
      2: return int'(nn2);
      default: return int'(nn3);
    endcase
  endfunction

  function automatic int dut_vel(int i);
    case (i)
      0: return int'(nv0);
      1: return int'(nv1);
      2: return int'(nv2);
      default: return int'(nv3);
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit pick_ce();
    case (ce_mode)
      0: return 1'b1;
      1: return bit'($urandom_range(0, 1));
      default: begin
        ce_tog = ~ce_tog;
        return ce_tog;
      end
    endcase
  endfunction

  task automatic step();
    ce = pick_ce();
    @(posedge clk);
    if (ce) ce_cnt++;
    @(negedge clk);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0; m_sus[i] = 1'b0;
    end
    m_prog = 0;
  endfunction

  function automatic void model_note_off(int n, bit sus);
    for (int i = 0; i < 4; i++) begin
      if (m_vel[i] != 0 && m_note[i] == n) begin
        if (sus) m_sus[i] = 1'b1;
        else begin
          m_vel[i] = 0;
          m_sus[i] = 1'b0;
        end
      end
    end
  endfunction

  function automatic void model_apply(int t, int n, int v, bit sus);
    int tgt;
    case (t)
      1: begin
        if (v == 0) model_note_off(n, sus);
        else begin
          tgt = -1;
          for (int i = 0; i < 4; i++)
            if (tgt < 0 && m_vel[i] != 0 && m_note[i] == n) tgt = i;
          for (int i = 0; i < 4; i++)
            if (tgt < 0 && m_vel[i] == 0) tgt = i;
          if (tgt < 0) begin
            tgt = 0;
            for (int i = 1; i < 4; i++)
              if (m_age[i] > m_age[tgt]) tgt = i;
          end
          for (int i = 0; i < 4; i++)
            if (i != tgt && m_vel[i] != 0 && m_age[i] < 255) m_age[i]++;
          m_note[tgt] = n;
          m_vel[tgt]  = v;
          m_age[tgt]  = 0;
          m_sus[tgt]  = 1'b0;
        end
      end
      0: model_note_off(n, sus);
      2: m_prog = n;
      default: begin
        for (int i = 0; i < 4; i++) begin
          m_vel[i] = 0; m_age[i] = 0; m_sus[i] = 1'b0;
        end
      end
    endcase
  endfunction

  function automatic void push_exp(int lat);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.note[i] = 7'(m_note[i]);
      e.vel[i]  = 7'(m_vel[i]);
    end
    e.prog = 7'(m_prog);
    e.due  = 32'(ce_cnt + lat);
    sb.push_back(e);
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!msg_ready && n < 300) begin
      step();
      n++;
    end
    if (!msg_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout actual=0 expected=1");
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !msg_ready) && n < 400) begin
      step();
      n++;
    end
    if (sb.size() != 0 || !msg_ready) begin
      checks++; errors++;
      $display("FAIL idle_timeout pending=%0d expected=0", sb.size());
    end
  endtask

  // Issue one message, wait for its transfer, then record the expectation.
  task automatic send(int t, int n, int v);
    bit done = 1'b0;
    int k = 0;
    wait_ready();
    if (msg_ready) begin
      msg_valid = 1'b1;
      msg_type  = 2'(t);
      d1        = 7'(n);
      d2        = 7'(v);
      while (!done && k < 100) begin
        ce = pick_ce();
        @(posedge clk);
        if (ce) begin
          ce_cnt++;
          done = 1'b1;
        end
        @(negedge clk);
        k++;
      end
      msg_valid = 1'b0;
      if (done) begin
        model_apply(t, n, v, tb_sus);
        push_exp((t < 2) ? 5 : 1);
      end else begin
        checks++; errors++;
        $display("FAIL transfer_timeout actual=0 expected=1");
      end
    end
  endtask

`ifdef VOICE_ALLOC_SUSTAIN_EN
  task automatic sus_rise();
    wait_idle();
    sustain = 1'b1;
    tb_sus  = 1'b1;
    ce = 1'b1;
    @(posedge clk); ce_cnt++; @(negedge clk);
  endtask

  task automatic sus_fall();
    wait_idle();
    sustain = 1'b0;
    tb_sus  = 1'b0;
    ce = 1'b1;
    @(posedge clk); ce_cnt++; @(negedge clk);
    check("sus_fall_ready_low", int'(msg_ready), 0);
    for (int i = 0; i < 4; i++) begin
      if (m_sus[i]) begin
        m_vel[i] = 0;
        m_sus[i] = 1'b0;
      end
    end
    push_exp(2);
  endtask
`endif

  // Monitor: every msg_ready rise marks a completed commit.
  initial begin : monitor
    bit   prev;
    exp_t e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = msg_ready;
      end else begin
        if (msg_ready && !prev) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_commit actual=1 expected=0");
          end else begin
            e = sb.pop_front();
            check("latency_ce", ce_cnt, int'(e.due));
            for (int i = 0; i < 4; i++) begin
              check($sformatf("sb_note%0d", i), dut_note(i), int'(e.note[i]));
              check($sformatf("sb_vel%0d", i), dut_vel(i), int'(e.vel[i]));
            end
            check("sb_program", int'(prog), int'(e.prog));
          end
        end
        prev = msg_ready;
      end
    end
  end

  initial begin : main
    int t, n, v;
    rst = 1'b1; ce = 1'b0; msg_valid = 1'b0;
    msg_type = 2'd0; d1 = 7'd0; d2 = 7'd0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
    sustain = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_ready", int'(msg_ready), 1);
    check("rst_program", int'(prog), 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_note%0d", i), dut_note(i), 0);
      check($sformatf("rst_vel%0d", i), dut_vel(i), 0);
    end
    rst = 1'b0;
    step();

    // Free-slot allocation in index order
    send(1, 60, 100);
    send(1, 62, 90);
    send(1, 64, 80);
    wait_idle();
    check("fill_note0", int'(nn0), 60); check("fill_vel0", int'(nv0), 100);
    check("fill_note1", int'(nn1), 62); check("fill_vel1", int'(nv1), 90);
    check("fill_note2", int'(nn2), 64); check("fill_vel2", int'(nv2), 80);
    check("fill_vel3", int'(nv3), 0);

    // Oldest-voice stealing
    send(1, 65, 70);
    send(1, 67, 50);
    wait_idle();
    check("steal_note0", int'(nn0), 67); check("steal_vel0", int'(nv0), 50);
    send(1, 69, 40);
    wait_idle();
    check("steal_note1", int'(nn1), 69); check("steal_vel1", int'(nv1), 40);

    // All-notes-off keeps note numbers
    send(3, 0, 0);
    wait_idle();
    check("alloff_vel0", int'(nv0), 0); check("alloff_vel3", int'(nv3), 0);
    check("alloff_note0", int'(nn0), 67);

    // Retrigger and zero-velocity note-on
    send(1, 62, 90);
    send(1, 62, 30);
    wait_idle();
    check("retrig_note0", int'(nn0), 62); check("retrig_vel0", int'(nv0), 30);
    check("retrig_vel1", int'(nv1), 0);
    send(1, 62, 0);
    wait_idle();
    check("vel0off_vel0", int'(nv0), 0); check("vel0off_note0", int'(nn0), 62);

    // Program change
    send(2, 5, 0);
    wait_idle();
    check("prog_value", int'(prog), 5);

    // Alternating ce through the scan
    ce_mode = 2;
    send(1, 70, 60);
    wait_idle();
    ce_mode = 0;
    check("ce_alt_note0", int'(nn0), 70); check("ce_alt_vel0", int'(nv0), 60);

    // Async reset in the middle of a scan drops the message
    send(1, 71, 20);
    step();
    step();
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", int'(msg_ready), 1);
    check("midrst_note0", int'(nn0), 0);
    check("midrst_vel0", int'(nv0), 0);
    check("midrst_program", int'(prog), 0);
    sb.delete();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    send(1, 72, 10);
    wait_idle();
    check("postrst_note0", int'(nn0), 72); check("postrst_vel1", int'(nv1), 0);

`ifdef VOICE_ALLOC_SUSTAIN_EN
    // Sustain hold then release on pedal up
    send(3, 0, 0);
    sus_rise();
    send(1, 60, 100);
    send(0, 60, 0);
    wait_idle();
    check("sus_held_vel0", int'(nv0), 100);
    sus_fall();
    wait_idle();
    check("sus_released_vel0", int'(nv0), 0);
    check("sus_released_note0", int'(nn0), 60);
`endif

    // Randomised traffic against the model
    for (int k = 0; k < 300; k++) begin
      ce_mode = ((k % 100) >= 50) ? 1 : 0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
      if ((k % 17) == 0) begin
        if (tb_sus) sus_fall();
        else sus_rise();
      end
`endif
      t = int'($urandom_range(0, 9));
      n = 60 + int'($urandom_range(0, 7));
      v = int'($urandom_range(1, 127));
      if ($urandom_range(0, 7) == 0) v = 0;
      if (t <= 5) send(1, n, v);
      else if (t <= 7) send(0, n, v);
      else if (t == 8) send(2, int'($urandom_range(0, 127)), 0);
      else if ($urandom_range(0, 3) == 0) send(3, 0, 0);
      else send(1, n, v);
    end
    ce_mode = 0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
